// File: rtl/prog_ram_loader.sv
// prog_ram_loader: run-time loadable program RAM.
// A byte stream (MSB first) is packed into instruction words and written to
// sequential addresses; the CPU is held until the requested words are resident,
// then fetches through the combinational read port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, no program resident, CPU held
//   LOAD  | accepting stream bytes, assembling and writing words
//   DONE  | program resident, CPU released, waiting for a reload request
module prog_ram_loader #(
   parameter int UNDEFINED      = 0,
   parameter int CNTR_WIDTH     = 5,
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int COMBINED_DATA  = ADDR_WIDTH + UNDEFINED + DATA_WIDTH,
   parameter int DEPTH          = 24,
   parameter int BYTES_PER_WORD = (COMBINED_DATA + 7) / 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_start,
   input  logic [CNTR_WIDTH-1:0]    word_count,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CNTR_WIDTH-1:0]    address,
   output logic [COMBINED_DATA-1:0] data_out,
   output logic                     cpu_hold,
   output logic                     load_done,
   output logic [CNTR_WIDTH-1:0]    words_loaded
);

   // Bits carried from earlier bytes of a word; the final byte supplies the low 8.
   localparam int PW  = COMBINED_DATA - 8;
   localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
   localparam logic [CNTR_WIDTH-1:0] DEPTH_C   = CNTR_WIDTH'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNTR_WIDTH-1:0]   n_q, n_d;
   logic [CNTR_WIDTH-1:0]   words_q, words_d;
   logic [BCW-1:0]          bcnt_q, bcnt_d;
   logic [PW-1:0]           acc_q, acc_d;
   logic                    we;
   logic [COMBINED_DATA-1:0] wdata;
   logic [CNTR_WIDTH-1:0]   n_lim;

   logic [COMBINED_DATA-1:0] mem_q [DEPTH];

   // State and counter registers; aborting a load on reset drops the partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         words_q <= '0;
         bcnt_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         words_q <= words_d;
         bcnt_q  <= bcnt_d;
         acc_q   <= acc_d;
      end
   end

   // Next-state, byte assembly and write strobe.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      words_d = words_q;
      bcnt_d  = bcnt_q;
      acc_d   = acc_q;
      we      = 1'b0;
      wdata   = {acc_q, in_data};
      n_lim   = (word_count > DEPTH_C) ? DEPTH_C : word_count;

      case (state_q)
         IDLE, DONE: begin
            if (load_start) begin
               n_d     = n_lim;
               words_d = '0;
               bcnt_d  = '0;
               state_d = (n_lim == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (in_valid) begin
               if (bcnt_q == LAST_BYTE) begin
                  we      = 1'b1;
                  words_d = words_q + CNTR_WIDTH'(1);
                  bcnt_d  = '0;
                  if (words_q == n_q - CNTR_WIDTH'(1)) begin
                     state_d = DONE;
                  end
               end else begin
                  // Truncation discards the padding bits at the top of byte 0.
                  acc_d  = PW'({acc_q, in_data});
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Program storage; deliberately not reset so a reset never erases code.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[words_q] <= wdata;
      end
   end

   assign data_out     = (address < DEPTH_C) ? mem_q[address] : '0;
   assign in_ready     = (state_q == LOAD);
   assign cpu_hold     = (state_q != DONE);
   assign load_done    = (state_q == DONE);
   assign words_loaded = words_q;

endmodule
